// File: rtl/ps2_key_sequencer.sv
// PS/2 scan-code sequencer: validates frames, tracks E0/F0/E1 prefixes, queues key events
// into a show-ahead FIFO and keeps a held-state bitmap for the extended arrow keys.
module ps2_key_sequencer #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned PTR_W      = 2
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        i_frame_valid,
    input  logic [10:0] i_frame,
    input  logic        i_ev_ready,
    output logic        o_ev_valid,
    output logic [7:0]  o_ev_code,
    output logic        o_ev_ext,
    output logic        o_ev_break,
    output logic [3:0]  o_held,
    output logic        o_err_frame,
    output logic        o_err_overflow,
    input  logic        i_clr_err
);

    typedef enum logic [2:0] {StIdle, StExt, StBrk, StExtBrk, StSkip} state_e;

    state_e      r_state, w_state_nxt;
    logic [2:0]  r_skip_cnt, w_skip_nxt;
    logic        w_emit, w_emit_ext, w_emit_brk;
    logic [7:0]  w_emit_code;

    logic [7:0]  w_data;
    logic        w_good, w_bad, w_ignore, w_is_e0, w_is_f0;

    // Event pipeline stage: decoded at frame edge, written to FIFO on the following edge
    logic        r_ev_v, r_ev_ext, r_ev_brk;
    logic [7:0]  r_ev_code;

    logic [9:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr, r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic             w_full, w_empty, w_push, w_pop, w_drop;

    logic [3:0]  r_held;
    logic        r_err_frame, r_err_overflow;

    assign w_data  = i_frame[8:1];
    assign w_good  = i_frame_valid & ~i_frame[0] & i_frame[10] & (^i_frame[9:1]);
    assign w_bad   = i_frame_valid & ~w_good;
    assign w_is_e0 = (w_data == 8'hE0);
    assign w_is_f0 = (w_data == 8'hF0);
    assign w_ignore = (w_data == 8'hAA) || (w_data == 8'hFA) || (w_data == 8'hFE) ||
                      (w_data == 8'hEE) || (w_data == 8'h00) || (w_data == 8'hFF);

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_state    <= StIdle;
            r_skip_cnt <= 3'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_skip_cnt <= w_skip_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_skip_nxt  = r_skip_cnt;
        w_emit      = 1'b0;
        w_emit_code = w_data;
        w_emit_ext  = 1'b0;
        w_emit_brk  = 1'b0;
        if (w_bad) begin
            w_state_nxt = StIdle;
            w_skip_nxt  = 3'd0;
        end else if (w_good) begin
            unique case (r_state)
                StIdle: begin
                    if (w_is_e0) begin
                        w_state_nxt = StExt;
                    end else if (w_is_f0) begin
                        w_state_nxt = StBrk;
                    end else if (w_data == 8'hE1) begin
                        w_state_nxt = StSkip;
                        w_skip_nxt  = 3'd7;
                    end else if (!w_ignore) begin
                        w_emit = 1'b1;
                    end
                end
                StExt: begin
                    if (w_is_f0) begin
                        w_state_nxt = StExtBrk;
                    end else if (!w_is_e0) begin
                        w_emit      = 1'b1;
                        w_emit_ext  = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
                StBrk: begin
                    if (!w_is_e0 && !w_is_f0) begin
                        w_emit      = 1'b1;
                        w_emit_brk  = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
                StExtBrk: begin
                    if (!w_is_e0 && !w_is_f0) begin
                        w_emit      = 1'b1;
                        w_emit_ext  = 1'b1;
                        w_emit_brk  = 1'b1;
                        w_state_nxt = StIdle;
                    end
                end
                StSkip: begin
                    w_skip_nxt = r_skip_cnt - 3'd1;
                    if (r_skip_cnt == 3'd1) begin
                        w_emit      = 1'b1;
                        w_emit_code = 8'hE1;
                        w_state_nxt = StIdle;
                    end
                end
                default: w_state_nxt = StIdle;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_ev_v      <= 1'b0;
            r_ev_code   <= 8'h00;
            r_ev_ext    <= 1'b0;
            r_ev_brk    <= 1'b0;
            r_err_frame <= 1'b0;
        end else begin
            r_ev_v      <= w_emit;
            r_ev_code   <= w_emit_code;
            r_ev_ext    <= w_emit_ext;
            r_ev_brk    <= w_emit_brk;
            r_err_frame <= w_bad;
        end
    end

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (PTR_W + 1)'(FIFO_DEPTH));
    assign w_pop   = ~w_empty & i_ev_ready;
    // A full FIFO still accepts the push when the head leaves in the same cycle
    assign w_push  = r_ev_v & (~w_full | w_pop);
    assign w_drop  = r_ev_v & w_full & ~w_pop;

    always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= {r_ev_code, r_ev_ext, r_ev_brk};
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_count        <= '0;
            r_err_overflow <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (w_pop && !w_push) r_count <= r_count - 1'b1;
            if (w_drop)         r_err_overflow <= 1'b1;
            else if (i_clr_err) r_err_overflow <= 1'b0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (reset) begin
            r_held <= 4'b0000;
        end else if (r_ev_v && r_ev_ext) begin
            case (r_ev_code)
                8'h75:   r_held[3] <= ~r_ev_brk;
                8'h72:   r_held[2] <= ~r_ev_brk;
                8'h6B:   r_held[1] <= ~r_ev_brk;
                8'h74:   r_held[0] <= ~r_ev_brk;
                default: ;
            endcase
        end
    end

    assign o_ev_valid = ~w_empty;
    assign {o_ev_code, o_ev_ext, o_ev_break} = w_empty ? 10'd0 : r_mem[r_rd_ptr];
    assign o_held         = r_held;
    assign o_err_frame    = r_err_frame;
    assign o_err_overflow = r_err_overflow;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Bench for ps2_key_sequencer: directed test-plan steps then random traffic, every cycle
// compared against a prefix-flag/queue reference model.
module tb_ps2_key_sequencer;

    localparam int unsigned DEPTH = 4;

    logic        sys_clk = 1'b0;
    logic        reset;
    logic        frame_valid;
    logic [10:0] frame;
    logic        ev_ready, clr_err;
    logic        ev_valid, ev_ext, ev_break, err_frame, err_overflow;
    logic [7:0]  ev_code;
    logic [3:0]  held;

    ps2_key_sequencer #(.FIFO_DEPTH(DEPTH), .PTR_W(2)) dut (
        .sys_clk        (sys_clk),
        .reset          (reset),
        .i_frame_valid  (frame_valid),
        .i_frame        (frame),
        .i_ev_ready     (ev_ready),
        .o_ev_valid     (ev_valid),
        .o_ev_code      (ev_code),
        .o_ev_ext       (ev_ext),
        .o_ev_break     (ev_break),
        .o_held         (held),
        .o_err_frame    (err_frame),
        .o_err_overflow (err_overflow),
        .i_clr_err      (clr_err)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    // Reference model: prefix flags, skip count, an event queue and a one-deep pending slot
    ev_t        q[$];
    ev_t        pend;
    bit         pend_v, m_ext, m_brk, m_ovf, m_errf;
    int         m_skip;
    logic [3:0] m_held;

    int vectors = 0;
    int miscompares = 0;

    function automatic logic [10:0] mkframe(input logic [7:0] d, input int corrupt);
        logic [10:0] f;
        f = {1'b1, ~^d, d, 1'b0};
        if (corrupt == 1) f[9]  = ~f[9];
        if (corrupt == 2) f[0]  = 1'b1;
        if (corrupt == 3) f[10] = 1'b0;
        return f;
    endfunction

    task automatic model(input bit fv, input logic [10:0] fr, input bit rdy, input bit clr,
                         input bit rst);
        bit         pop, drop, good;
        logic [7:0] d;
        if (rst) begin
            q.delete();
            pend_v = 0; m_ext = 0; m_brk = 0; m_skip = 0;
            m_held = 4'b0000; m_ovf = 0; m_errf = 0;
            return;
        end
        pop  = (q.size() != 0) && rdy;
        drop = 0;
        if (pop) void'(q.pop_front());
        if (pend_v) begin
            if (q.size() < DEPTH) q.push_back(pend);
            else drop = 1;
            if (pend.ext) begin
                if (pend.code == 8'h75) m_held[3] = ~pend.brk;
                if (pend.code == 8'h72) m_held[2] = ~pend.brk;
                if (pend.code == 8'h6B) m_held[1] = ~pend.brk;
                if (pend.code == 8'h74) m_held[0] = ~pend.brk;
            end
        end
        if (drop) m_ovf = 1;
        else if (clr) m_ovf = 0;
        pend_v = 0;
        m_errf = 0;
        if (!fv) return;
        d    = fr[8:1];
        good = !fr[0] && fr[10] && (^fr[9:1]);
        if (!good) begin
            m_errf = 1; m_ext = 0; m_brk = 0; m_skip = 0;
        end else if (m_skip > 0) begin
            m_skip--;
            if (m_skip == 0) begin
                pend = '{code: 8'hE1, ext: 1'b0, brk: 1'b0};
                pend_v = 1;
            end
        end else if (!m_ext && !m_brk) begin
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else if (d == 8'hE1) m_skip = 7;
            else if (!(d inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF})) begin
                pend = '{code: d, ext: 1'b0, brk: 1'b0};
                pend_v = 1;
            end
        end else if (d == 8'hE0 || d == 8'hF0) begin
            if (d == 8'hF0 && m_ext) m_brk = 1;
        end else begin
            pend = '{code: d, ext: m_ext, brk: m_brk};
            pend_v = 1;
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        ev_t h;
        h = (q.size() != 0) ? q[0] : '0;
        check("ev_valid", 16'(ev_valid), 16'(q.size() != 0));
        check("ev_code", 16'(ev_code), 16'(h.code));
        check("ev_ext", 16'(ev_ext), 16'(h.ext));
        check("ev_break", 16'(ev_break), 16'(h.brk));
        check("held", 16'(held), 16'(m_held));
        check("err_frame", 16'(err_frame), 16'(m_errf));
        check("err_overflow", 16'(err_overflow), 16'(m_ovf));
    endtask

    task automatic cyc(input bit fv, input logic [10:0] fr, input bit rdy, input bit clr,
                       input bit rst);
        @(negedge sys_clk);
        frame_valid = fv; frame = fr; ev_ready = rdy; clr_err = clr; reset = rst;
        model(fv, fr, rdy, clr, rst);
        @(posedge sys_clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] d, input int corrupt, input bit rdy);
        cyc(1'b1, mkframe(d, corrupt), rdy, 1'b0, 1'b0);
        cyc(1'b0, 11'd0, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] picks [12];
        logic [7:0] b;
        logic [7:0] seq [8];
        picks = '{8'hE0, 8'hF0, 8'hE1, 8'h75, 8'h72, 8'h6B, 8'h74, 8'hAA, 8'h00, 8'h1C,
                  8'hFA, 8'h1D};
        seq   = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        frame_valid = 0; frame = '0; ev_ready = 1; clr_err = 0; reset = 1;

        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b1);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b1);
        check("reset_valid", 16'(ev_valid), 16'd0);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);

        // 1D make; consumed immediately
        send(8'h1D, 0, 1'b1);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);

        send(8'hE0, 0, 1'b1);
        send(8'h75, 0, 1'b1);
        check("held_up_set", 16'(held), 16'h8);
        send(8'hE0, 0, 1'b1);
        send(8'hF0, 0, 1'b1);
        send(8'h75, 0, 1'b1);
        check("held_up_clr", 16'(held), 16'h0);

        send(8'hE0, 0, 1'b1);
        send(8'h6B, 1, 1'b1);
        send(8'h6B, 0, 1'b1);
        check("held_unchanged", 16'(held), 16'h0);

        for (int i = 0; i < 8; i++) send(seq[i], 0, 1'b1);
        send(8'hAA, 0, 1'b1);
        send(8'hFA, 0, 1'b1);

        send(8'h1C, 0, 1'b0);
        send(8'h1B, 0, 1'b0);
        send(8'h23, 0, 1'b0);
        send(8'h2B, 0, 1'b0);
        send(8'h34, 0, 1'b0);
        send(8'h33, 0, 1'b0);
        check("ovf_set", 16'(err_overflow), 16'd1);
        check("fifo_head", 16'(ev_code), 16'h1C);
        cyc(1'b0, 11'd0, 1'b0, 1'b1, 1'b0);
        check("ovf_clr", 16'(err_overflow), 16'd0);
        // Full FIFO: frame with ready low, then push edge coincides with a pop
        cyc(1'b1, mkframe(8'h15, 0), 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);
        check("no_new_ovf", 16'(err_overflow), 16'd0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b0);

        send(8'hE0, 0, 1'b1);
        send(8'hF0, 0, 1'b1);
        cyc(1'b0, 11'd0, 1'b1, 1'b0, 1'b1);
        send(8'h74, 0, 1'b1);
        check("held_after_rst", 16'(held), 16'h0);

        for (int i = 0; i < 3000; i++) begin
            int r;
            bit fv;
            r  = int'($urandom_range(0, 15));
            b  = (r < 12) ? picks[r] : 8'($urandom);
            fv = ($urandom_range(0, 2) != 0);
            cyc(fv, mkframe(b, ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, 3)) : 0),
                ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ps2_key_sequencer.md
Name: ps2_key_sequencer

Overview:
- Sits downstream of the PS/2 receive controller, shift register and bit counter in the keyboard path.
- Takes each completed 11-bit frame, validates it, and runs the scan-code prefix state machine (E0 extended, F0 break, E1 pause).
- Queues decoded key events in a small FIFO with a valid/ready handshake toward the Sokoban game logic.
- Keeps a live held-state bitmap for the four arrow keys.

Parameters:
- FIFO_DEPTH, 4, number of event entries; power of two, minimum 2.
- PTR_W, 2, log2(FIFO_DEPTH).

Ports:
- sys_clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- frame_valid  in  1  one-cycle pulse: frame holds a complete 11-bit frame
- frame  in  11  [0]=start, [8:1]=data LSB-first, [9]=parity, [10]=stop
- ev_ready  in  1  consumer accepts the head event
- ev_valid  out  1  FIFO non-empty
- ev_code  out  8  head event scan code
- ev_ext  out  1  head event had E0 prefix
- ev_break  out  1  head event is a release (F0)
- held  out  4  {up,down,left,right} currently pressed
- err_frame  out  1  one-cycle pulse on a bad frame
- err_overflow  out  1  sticky; an event was dropped on a full FIFO
- clr_err  in  1  clears err_overflow

Behaviour:
- Reset (sys_clk, synchronous, active-high; applies at any time, including mid-sequence):
  - FSM goes to IDLE and the skip counter clears.
  - FIFO empties: ev_valid=0; ev_code, ev_ext, ev_break read 0.
  - held=0, err_frame=0, err_overflow=0.
- Frame check on frame_valid: good iff frame[0]=0, frame[10]=1, and XOR(frame[9:1])=1 (odd parity). data=frame[8:1].
- Bad frame:
  - err_frame=1 in the next cycle.
  - FSM returns to IDLE; any pending prefix is discarded; no event is produced.
- FSM states and transitions (good frames only; other cycles hold state):
  - IDLE:
    - E0 -> EXT
    - F0 -> BRK
    - E1 -> SKIP with skip counter=7
    - AA, FA, FE, EE, 00, FF -> discarded, stay IDLE
    - any other byte -> emit {code,ext=0,brk=0}
  - EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> emit {code,1,0}, go IDLE.
  - BRK: F0 or E0 -> stay BRK (treated as noise); other -> emit {code,0,1}, go IDLE.
  - EXT_BRK: F0 or E0 -> stay; other -> emit {code,1,1}, go IDLE.
  - SKIP:
    - Each good frame decrements the counter, content ignored.
    - When the counter reaches 0, emit {E1,0,0} once and go IDLE.
    - A bad frame aborts to IDLE without emitting.
- Latency and FIFO:
  - frame_valid at edge N -> event written at edge N+1.
  - The FIFO is show-ahead: if it was empty, ev_valid=1 with the event fields during the cycle after N+1.
  - A pop occurs when ev_valid and ev_ready are both high.
- Held bitmap:
  - Extended codes only: 75=up, 72=down, 6B=left, 74=right.
  - Make sets the bit and break clears it, written at the same edge as the emit.
  - Updates regardless of FIFO room.
  - Non-extended codes never touch held.
- Full FIFO:
  - Push while full with no simultaneous pop -> the new event is dropped and err_overflow=1.
  - Push and pop in the same cycle while full -> both take effect; no drop.
  - Pop while empty is ignored.
- err_overflow:
  - Stays set until clr_err=1, which clears it on the next edge.
  - If clr_err and a new drop occur in the same cycle, err_overflow=1 wins.
- Pointer arithmetic: PTR_W-bit read/write pointers wrap modulo FIFO_DEPTH, plus an occupancy count of width PTR_W+1.

Test Plan:
- Good frame, data 0x1D (start=0, parity=1, stop=1), ev_ready=1 -> ev_valid=1 for one cycle with ev_code=1D, ev_ext=0, ev_break=0; held=0.
- Frames E0, 75 -> event {75,1,0} and held=1000. Then E0, F0, 75 -> event {75,1,1} and held=0000.
- E0 frame, then 6B frame with a parity error -> err_frame pulse, no event. Then 6B alone -> event {6B,0,0}, held unchanged.
- E1, 14, 77, E1, F0, 14, F0, 77 -> exactly one event {E1,0,0}, after the eighth frame. Frames AA and FA -> no events.
- ev_ready=0, six make codes 1C 1B 23 2B 34 33 -> events 1C 1B 23 2B retained in order; err_overflow=1. clr_err -> err_overflow=0. With FIFO full, a push coinciding with a pop -> no new overflow.
- Frames E0, F0, then reset, then 74 -> event {74,0,0} (prefix lost), held=0.
